// File: rtl/GlobalsPKG.sv
// Shared game-wide constants and types: level element encoding, grabbable
// object metadata layout, grid geometry and the object-table state encoding.
package GlobalsPKG;

  localparam int MAX_OBJECTS = 20;
  localparam int GRID_ROWS   = 15;
  localparam int GRID_COLS   = 20;
  localparam int GRID_CELLS  = GRID_ROWS * GRID_COLS;
  localparam int SLOT_W      = $clog2(MAX_OBJECTS);

  // Kind of thing occupying a grid cell; FILLER marks "nothing here".
  typedef enum logic [2:0] {
    FILLER      = 3'd0,
    VALUABLE_1  = 3'd1,
    VALUABLE_2  = 3'd2,
    VALUABLE_3  = 3'd3,
    ROCK_1      = 3'd4,
    ROCK_2      = 3'd5,
    BOMB        = 3'd6,
    MYSTERY_BAG = 3'd7
  } LEVEL_ELEMENTS;

  // One grabbable object: what it is and which grid cell it sits in.
  typedef struct packed {
    LEVEL_ELEMENTS element;
    logic [8:0]    index;
  } GRABBABLE_OBJECT_METADATA;

  // Object table control states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    SCAN  = 3'd3,
    RESP  = 3'd4
  } TABLE_STATE;

  // True for the element kinds that count towards level completion.
  function automatic logic is_valuable(input LEVEL_ELEMENTS e);
    logic v;
    case (e)
      VALUABLE_1: v = 1'b1;
      VALUABLE_2: v = 1'b1;
      VALUABLE_3: v = 1'b1;
      default:    v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/grab_object_table.sv
// Live table of grabbable objects for the current level. Filled by the level
// loader, then answers "which object is in cell N" queries from the hook by a
// linear one-slot-per-cycle scan, optionally removing the object it finds.
module grab_object_table
  import GlobalsPKG::*;
#(
  parameter int MAX_OBJECTS = GlobalsPKG::MAX_OBJECTS,
  parameter int GRID_ROWS   = GlobalsPKG::GRID_ROWS,
  parameter int GRID_COLS   = GlobalsPKG::GRID_COLS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  GRABBABLE_OBJECT_METADATA ld_obj,
  input  logic                     ld_last,
  input  logic                     q_valid,
  output logic                     q_ready,
  input  logic [8:0]               q_index,
  input  logic                     q_take,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output GRABBABLE_OBJECT_METADATA resp_obj,
  output logic [4:0]               resp_slot,
  output logic [4:0]               valuables_left,
  output logic                     level_clear,
  output logic                     load_err
);

  localparam int SW = (MAX_OBJECTS > 1) ? $clog2(MAX_OBJECTS) : 1;
  localparam int FW = $clog2(MAX_OBJECTS + 1);
  localparam logic [FW-1:0] MAX_F     = FW'(MAX_OBJECTS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(MAX_OBJECTS - 1);
  localparam logic [9:0]    CELLS     = 10'(GRID_ROWS * GRID_COLS);

  // Storage: metadata plus a separate occupancy vector, so an empty slot never
  // needs a FILLER encoding.
  GRABBABLE_OBJECT_METADATA meta_r [MAX_OBJECTS];
  logic [MAX_OBJECTS-1:0]   occ_r;

  TABLE_STATE               state_r;
  logic [FW-1:0]            fill_r;
  logic [SW-1:0]            scan_r;
  logic [8:0]               q_index_r;
  logic                     take_r;
  logic                     hit_r;
  logic [SW-1:0]            slot_r;
  logic [4:0]               val_cnt_r;
  logic                     ld_ready_r;
  logic                     q_ready_r;
  logic                     resp_valid_r;
  logic                     resp_hit_r;
  GRABBABLE_OBJECT_METADATA resp_obj_r;
  logic [4:0]               resp_slot_r;
  logic                     level_clear_r;
  logic                     load_err_r;

  logic                     ld_fire_s;
  logic                     ld_oor_s;
  logic                     ld_store_s;
  logic                     q_fire_s;
  logic                     scan_hit_s;
  logic                     take_clear_s;
  TABLE_STATE               state_next_s;
  logic [FW-1:0]            fill_next_s;
  logic [4:0]               cnt_next_s;

  assign ld_fire_s    = (state_r == LOAD) && ld_ready_r && ld_valid;
  assign ld_oor_s     = ({1'b0, ld_obj.index} >= CELLS);
  assign ld_store_s   = ld_fire_s && !ld_oor_s && (ld_obj.element != FILLER);
  assign q_fire_s     = (state_r == READY) && q_ready_r && q_valid;
  assign scan_hit_s   = occ_r[scan_r] && (meta_r[scan_r].index == q_index_r);
  assign take_clear_s = (state_r == RESP) && hit_r && take_r;

  // Next state, fill pointer and valuables count for the current cycle.
  always_comb begin
    state_next_s = state_r;
    fill_next_s  = fill_r;
    cnt_next_s   = val_cnt_r;
    case (state_r)
      IDLE: begin
        state_next_s = IDLE;
      end
      LOAD: begin
        if (ld_fire_s) begin
          fill_next_s = fill_r + FW'(1);
          if (ld_store_s && is_valuable(ld_obj.element)) begin
            cnt_next_s = val_cnt_r + 5'd1;
          end else begin
            cnt_next_s = val_cnt_r;
          end
          if (ld_last || (fill_next_s == MAX_F)) begin
            state_next_s = READY;
          end else begin
            state_next_s = LOAD;
          end
        end else begin
          state_next_s = LOAD;
        end
      end
      READY: begin
        if (q_fire_s) begin
          state_next_s = SCAN;
        end else begin
          state_next_s = READY;
        end
      end
      SCAN: begin
        if (scan_hit_s || (scan_r == LAST_SLOT)) begin
          state_next_s = RESP;
        end else begin
          state_next_s = SCAN;
        end
      end
      RESP: begin
        state_next_s = READY;
        if (take_clear_s && is_valuable(meta_r[slot_r].element)) begin
          cnt_next_s = val_cnt_r - 5'd1;
        end else begin
          cnt_next_s = val_cnt_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Slot payload capture; contents only matter where occ_r marks the slot live.
  always_ff @(posedge clk) begin
    if (ld_store_s && !reset && !load_start) begin
      meta_r[fill_r[SW-1:0]] <= ld_obj;
    end
  end

  // Control state, occupancy, scan bookkeeping and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset || load_start) begin
      state_r       <= reset ? IDLE : LOAD;
      ld_ready_r    <= reset ? 1'b0 : (MAX_OBJECTS > 0);
      fill_r        <= '0;
      occ_r         <= '0;
      scan_r        <= '0;
      q_index_r     <= 9'd0;
      take_r        <= 1'b0;
      hit_r         <= 1'b0;
      slot_r        <= '0;
      val_cnt_r     <= 5'd0;
      q_ready_r     <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_hit_r    <= 1'b0;
      resp_obj_r    <= '0;
      resp_slot_r   <= 5'd0;
      level_clear_r <= 1'b0;
      load_err_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      fill_r       <= fill_next_s;
      val_cnt_r    <= cnt_next_s;
      resp_valid_r <= 1'b0;
      case (state_r)
        LOAD: begin
          if (ld_store_s) begin
            occ_r[fill_r[SW-1:0]] <= 1'b1;
          end
          if (ld_fire_s && ld_oor_s) begin
            load_err_r <= 1'b1;
          end
        end
        READY: begin
          if (q_fire_s) begin
            q_index_r <= q_index;
            take_r    <= q_take;
            scan_r    <= '0;
          end
        end
        SCAN: begin
          if (scan_hit_s) begin
            hit_r  <= 1'b1;
            slot_r <= scan_r;
          end else if (scan_r == LAST_SLOT) begin
            hit_r  <= 1'b0;
            slot_r <= '0;
          end else begin
            scan_r <= scan_r + SW'(1);
          end
        end
        RESP: begin
          resp_valid_r <= 1'b1;
          resp_hit_r   <= hit_r;
          resp_obj_r   <= hit_r ? meta_r[slot_r] : '0;
          resp_slot_r  <= hit_r ? 5'(slot_r) : 5'd0;
          if (take_clear_s) begin
            occ_r[slot_r] <= 1'b0;
          end
        end
        default: begin
        end
      endcase
      ld_ready_r    <= (state_next_s == LOAD) && (fill_next_s < MAX_F);
      // Held low for one cycle after each response so a query never overlaps it.
      q_ready_r     <= (state_r == READY) && !q_fire_s;
      level_clear_r <= (state_next_s == READY) && (cnt_next_s == 5'd0);
    end
  end

  assign ld_ready       = ld_ready_r;
  assign q_ready        = q_ready_r;
  assign resp_valid     = resp_valid_r;
  assign resp_hit       = resp_hit_r;
  assign resp_obj       = resp_obj_r;
  assign resp_slot      = resp_slot_r;
  assign valuables_left = val_cnt_r;
  assign level_clear    = level_clear_r;
  assign load_err       = load_err_r;

endmodule

// File: tb/tb_grab_object_table.sv
// Directed bench for grab_object_table: load, hit/miss latency, take and
// level clear, drop rules, overflow, abort and reset.
module tb_grab_object_table;
  import GlobalsPKG::*;

  logic                     clk;
  logic                     reset;
  logic                     load_start;
  logic                     ld_valid;
  logic                     ld_ready;
  GRABBABLE_OBJECT_METADATA ld_obj;
  logic                     ld_last;
  logic                     q_valid;
  logic                     q_ready;
  logic [8:0]               q_index;
  logic                     q_take;
  logic                     resp_valid;
  logic                     resp_hit;
  GRABBABLE_OBJECT_METADATA resp_obj;
  logic [4:0]               resp_slot;
  logic [4:0]               valuables_left;
  logic                     level_clear;
  logic                     load_err;

  int checks = 0;
  int errors = 0;

  grab_object_table dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_obj(ld_obj), .ld_last(ld_last),
    .q_valid(q_valid), .q_ready(q_ready), .q_index(q_index), .q_take(q_take),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_obj(resp_obj),
    .resp_slot(resp_slot), .valuables_left(valuables_left),
    .level_clear(level_clear), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic load_entry(input LEVEL_ELEMENTS el, input logic [8:0] idx, input logic last);
    int n;
    n = 0;
    ld_valid = 1'b1;
    ld_obj   = '{el, idx};
    ld_last  = last;
    while (ld_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("ld_ready_wait", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_query(input string tag, input logic [8:0] idx, input logic tk,
                          input int exp_lat, input logic exp_hit,
                          input logic [11:0] exp_obj, input logic [4:0] exp_slot);
    int n;
    n = 0;
    while (q_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_q_ready_wait"}, 32'(q_ready), 32'd1);
    q_valid = 1'b1;
    q_index = idx;
    q_take  = tk;
    tick();
    q_valid = 1'b0;
    q_take  = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_hit"}, 32'(resp_hit), 32'(exp_hit));
    check({tag, "_obj"}, 32'(resp_obj), 32'(exp_obj));
    check({tag, "_slot"}, 32'(resp_slot), 32'(exp_slot));
    check({tag, "_q_ready_during_resp"}, 32'(q_ready), 32'd0);
    tick();
    check({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, "_q_ready_after"}, 32'(q_ready), 32'd1);
  endtask

  initial begin
    int acc;
    int cnt;
    int n;
    reset = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_obj = '0; ld_last = 1'b0;
    q_valid = 1'b0; q_index = 9'd0; q_take = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values, state IDLE.
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_q_ready", 32'(q_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_obj", 32'(resp_obj), 32'd0);
    check("rst_valuables", 32'(valuables_left), 32'd0);
    check("rst_level_clear", 32'(level_clear), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);

    // Basic load and hit.
    pulse_load_start();
    check("ls_ld_ready", 32'(ld_ready), 32'd1);
    load_entry(VALUABLE_1, 9'd45, 1'b0);
    load_entry(ROCK_1, 9'd100, 1'b0);
    load_entry(VALUABLE_3, 9'd299, 1'b1);
    check("basic_ld_ready_off", 32'(ld_ready), 32'd0);
    check("basic_q_ready_entry", 32'(q_ready), 32'd0);
    check("basic_valuables", 32'(valuables_left), 32'd2);
    tick();
    check("basic_q_ready_next", 32'(q_ready), 32'd1);
    check("basic_level_clear", 32'(level_clear), 32'd0);
    do_query("q100", 9'd100, 1'b0, 3, 1'b1, {ROCK_1, 9'd100}, 5'd1);

    // Take to level clear.
    do_query("take45", 9'd45, 1'b1, 2, 1'b1, {VALUABLE_1, 9'd45}, 5'd0);
    check("take45_valuables", 32'(valuables_left), 32'd1);
    check("take45_level_clear", 32'(level_clear), 32'd0);
    do_query("take299", 9'd299, 1'b1, 4, 1'b1, {VALUABLE_3, 9'd299}, 5'd2);
    check("take299_valuables", 32'(valuables_left), 32'd0);
    check("take299_level_clear", 32'(level_clear), 32'd1);
    do_query("miss45", 9'd45, 1'b0, 21, 1'b0, 12'd0, 5'd0);

    // Drop rules.
    pulse_load_start();
    load_entry(ROCK_1, 9'd300, 1'b0);
    check("drop_load_err", 32'(load_err), 32'd1);
    load_entry(FILLER, 9'd10, 1'b0);
    load_entry(VALUABLE_2, 9'd200, 1'b1);
    check("drop_valuables", 32'(valuables_left), 32'd1);
    check("drop_load_err_sticky", 32'(load_err), 32'd1);
    do_query("miss10", 9'd10, 1'b0, 21, 1'b0, 12'd0, 5'd0);

    // Overflow: 22 entries streamed without a last marker.
    pulse_load_start();
    check("ovf_load_err_cleared", 32'(load_err), 32'd0);
    acc = 0;
    for (int i = 0; i < 22; i++) begin
      ld_valid = 1'b1;
      ld_obj   = '{ROCK_2, 9'(i)};
      if (ld_ready === 1'b1) acc++;
      tick();
    end
    ld_valid = 1'b0;
    check("ovf_accepted", 32'(acc), 32'd20);
    check("ovf_ld_ready", 32'(ld_ready), 32'd0);
    check("ovf_q_ready", 32'(q_ready), 32'd1);
    check("ovf_level_clear", 32'(level_clear), 32'd1);
    do_query("ovf_slot19", 9'd19, 1'b0, 21, 1'b1, {ROCK_2, 9'd19}, 5'd19);
    do_query("ovf_miss20", 9'd20, 1'b0, 21, 1'b0, 12'd0, 5'd0);

    // Abort a scan with load_start.
    pulse_load_start();
    load_entry(VALUABLE_1, 9'd7, 1'b1);
    check("abort_valuables_before", 32'(valuables_left), 32'd1);
    n = 0;
    while (q_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("abort_q_ready_wait", 32'(q_ready), 32'd1);
    q_valid = 1'b1;
    q_index = 9'd250;
    tick();
    q_valid = 1'b0;
    tick();
    tick();
    pulse_load_start();
    check("abort_ld_ready", 32'(ld_ready), 32'd1);
    check("abort_valuables", 32'(valuables_left), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_q_ready", 32'(q_ready), 32'd0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (resp_valid === 1'b1) cnt++;
    end
    check("abort_no_resp", 32'(cnt), 32'd0);
    check("abort_still_loading", 32'(ld_ready), 32'd1);

    // Duplicate index: lowest slot wins, then the next copy.
    pulse_load_start();
    load_entry(VALUABLE_2, 9'd45, 1'b0);
    load_entry(ROCK_1, 9'd60, 1'b0);
    load_entry(ROCK_2, 9'd61, 1'b0);
    load_entry(VALUABLE_1, 9'd45, 1'b1);
    check("dup_valuables", 32'(valuables_left), 32'd2);
    do_query("dup_first", 9'd45, 1'b1, 2, 1'b1, {VALUABLE_2, 9'd45}, 5'd0);
    check("dup_first_valuables", 32'(valuables_left), 32'd1);
    do_query("dup_second", 9'd45, 1'b1, 5, 1'b1, {VALUABLE_1, 9'd45}, 5'd3);
    check("dup_second_valuables", 32'(valuables_left), 32'd0);
    check("dup_level_clear", 32'(level_clear), 32'd1);

    // Reset in the middle of a load.
    pulse_load_start();
    load_entry(VALUABLE_3, 9'd5, 1'b0);
    check("midload_valuables", 32'(valuables_left), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
    check("mid_rst_q_ready", 32'(q_ready), 32'd0);
    check("mid_rst_valuables", 32'(valuables_left), 32'd0);
    check("mid_rst_resp_obj", 32'(resp_obj), 32'd0);
    check("mid_rst_resp_slot", 32'(resp_slot), 32'd0);
    check("mid_rst_resp_hit", 32'(resp_hit), 32'd0);
    check("mid_rst_level_clear", 32'(level_clear), 32'd0);
    tick();
    tick();
    check("mid_rst_idle_ld_ready", 32'(ld_ready), 32'd0);
    check("mid_rst_idle_q_ready", 32'(q_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grab_object_table.md
# grab_object_table

Holds the live set of grabbable objects for the current level; it sits between the level loader and the hook/collision logic. Objects are streamed in through a ready/valid load port at level start and stored as `GRABBABLE_OBJECT_METADATA` slots. Afterwards the block answers "what object occupies grid cell N" queries from the hook. A query can optionally remove the object it hits, and the block tracks the remaining valuables for level-clear detection.

## Interface
Parameters:
- `MAX_OBJECTS`, default `GlobalsPKG::MAX_OBJECTS` (20): number of slots.
- `GRID_ROWS`, default 15: grid rows.
- `GRID_COLS`, default 20: grid columns; cell index = row*GRID_COLS + col.

Ports:
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `load_start` in 1: pulse; clears the table and enters LOAD from any state.
- `ld_valid` in 1: load entry valid.
- `ld_ready` out 1: table accepts a load entry.
- `ld_obj` in 12: `GRABBABLE_OBJECT_METADATA` entry.
- `ld_last` in 1: final entry of the level.
- `q_valid` in 1: query request.
- `q_ready` out 1: query accepted when high together with `q_valid`.
- `q_index` in 9: grid cell to look up.
- `q_take` in 1: remove the hit object; sampled with `q_index`.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_hit` out 1: an object was found.
- `resp_obj` out 12: metadata of the hit object; all-zero on a miss.
- `resp_slot` out 5: slot number of the hit; 0 on a miss.
- `valuables_left` out 5: count of stored VALUABLE_1..3 entries.
- `level_clear` out 1: READY and `valuables_left`==0.
- `load_err` out 1: sticky; an out-of-range index was dropped. Cleared by `load_start` or `reset`.

## Operation
States:
- **IDLE**: table empty; `ld_ready`=0, `q_ready`=0.
- **LOAD**:
  - `ld_ready`=1 while the fill pointer is below MAX_OBJECTS.
  - Each handshake writes `ld_obj` into slot[fill] and increments fill.
  - FILLER entries and entries with index ≥ GRID_ROWS*GRID_COLS (300) consume the handshake but are not stored. An out-of-range index also sets `load_err`.
  - A handshake with `ld_last`=1, or fill reaching MAX_OBJECTS, moves to READY.
- **READY**: `q_ready`=1. An accepted query latches `q_index`/`q_take`, sets the scan pointer to 0, and moves to SCAN.
- **SCAN**:
  - Examines one slot per cycle, from slot 0 upward.
  - The first occupied slot whose index equals the latched index is the hit; the scan stops there.
  - On reaching MAX_OBJECTS-1 with no hit, the result is a miss.
  - In both cases the state moves to RESP with the results registered.
- **RESP**:
  - `resp_valid`=1 for one cycle.
  - On a hit with take, the slot is cleared on the same edge that raises `resp_valid`. `valuables_left` decrements on that edge only if the element type is VALUABLE_1..3.
  - Returns to READY.

Other behaviour:
- No duplicate-index checking at load; the lowest slot with a given index wins.
- `load_start` in SCAN/RESP aborts: no `resp_valid` is issued and the table is cleared. `load_start` takes priority over a same-cycle load handshake or query.
- `valuables_left` increments on each stored valuable during LOAD. It is 5 bits and saturates at MAX_OBJECTS by construction.

## Timing
- All outputs are registered.
- Values after `reset` and after `load_start`: all slots empty, fill=0, `valuables_left`=0, `load_err`=0, `resp_*`=0.
  - State is IDLE after `reset` and LOAD after `load_start`.
  - `level_clear`=0, because it is defined only in READY.
- Query accepted on edge E0; slot k is examined in the cycle after edge E0+k.
  - A hit at slot k gives `resp_valid` high in cycle E0+k+2.
  - A miss gives `resp_valid` in cycle E0+MAX_OBJECTS+1 (21).
- `q_ready` is low from acceptance until the cycle after `resp_valid`. There is at most one query outstanding.
- A load entry is usable by a query the cycle after READY is entered.

## Structure
- In GlobalsPKG, add:
  - `GRID_CELLS` = GRID_ROWS*GRID_COLS.
  - `SLOT_W` = $clog2(MAX_OBJECTS).
  - A `TABLE_STATE` enum: IDLE, LOAD, READY, SCAN, RESP.
- Reuse `LEVEL_ELEMENTS` and `GRABBABLE_OBJECT_METADATA` unchanged.
- Occupancy is a separate MAX_OBJECTS-bit vector, so FILLER is never stored.
- No sub-module: slot storage, FSM and scan fit in one module of about 200 lines.

## Test plan
- **Basic load and hit:** load {VALUABLE_1@45, ROCK_1@100, VALUABLE_3@299 last}, then query 100 → `resp_hit`=1, `resp_obj`={ROCK_1,100}, `resp_slot`=1, `resp_valid` 3 cycles after acceptance; `valuables_left`=2.
- **Take to level clear:** same table, query 45 with take, then query 299 with take → `valuables_left` goes 2→1→0, `level_clear` rises after the second response. A repeat query to 45 → miss at latency 21.
- **Drop rules:** load an entry with index 300 and a FILLER@10 → both handshakes complete but nothing is stored; `load_err`=1; a query to 10 misses.
- **Overflow:** stream 22 entries without `ld_last` → `ld_ready` drops after the 20th and the state is READY; entries 21–22 are not accepted.
- **Abort:** `load_start` two cycles into a SCAN → no `resp_valid`, `valuables_left`=0, `ld_ready`=1 the next cycle.
- **Duplicate index and reset:** duplicate index 45 in slots 0 and 3, take twice → first response reports slot 0, second reports slot 3. Then `reset` mid-LOAD → all outputs at their reset values and the state is IDLE.
